// File: rtl/axi4_lite_master_q.sv
// AXI4-Lite master with a posted write queue, single-outstanding reads,
// write-error accounting and per-channel watchdog flags.
module axi4_lite_master_q #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int WFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]     AMCI_WADDR,
  input  logic [AXI_DATA_WIDTH-1:0]     AMCI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   AMCI_WSTRB,
  input  logic                          AMCI_WRITE,
  output logic                          AMCI_WFULL,
  output logic [$clog2(WFIFO_DEPTH):0]  AMCI_WPENDING,
  output logic                          AMCI_WIDLE,
  output logic [1:0]                    AMCI_WRESP,
  output logic [15:0]                   AMCI_WERRCNT,
  output logic                          AMCI_WOVERFLOW,
  output logic                          AMCI_WTIMEOUT,
  input  logic [AXI_ADDR_WIDTH-1:0]     AMCI_RADDR,
  input  logic                          AMCI_READ,
  output logic                          AMCI_RIDLE,
  output logic [AXI_DATA_WIDTH-1:0]     AMCI_RDATA,
  output logic [1:0]                    AMCI_RRESP,
  output logic                          AMCI_RVALID,
  output logic                          AMCI_RTIMEOUT,
  input  logic                          AMCI_CLEAR,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_BUSY} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [AXI_ADDR_WIDTH-1:0] q_addr [WFIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] q_data [WFIFO_DEPTH];
  logic [SW-1:0]             q_strb [WFIFO_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW:0]               q_count;
  logic                      push;
  logic                      pop;
  logic                      aw_ok;
  logic                      w_ok;
  logic [TW-1:0]             w_wd;
  logic [TW-1:0]             r_wd;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b001;

  assign AMCI_WFULL    = (q_count == (PW+1)'(WFIFO_DEPTH));
  assign push          = AMCI_WRITE && !AMCI_WFULL;
  assign pop           = (wstate == W_IDLE) && (q_count != '0);
  assign AMCI_WPENDING = q_count + {{PW{1'b0}}, (wstate != W_IDLE)};
  assign AMCI_WIDLE    = (q_count == '0) && (wstate == W_IDLE) && !AMCI_WRITE;
  assign AMCI_RIDLE    = (rstate == R_IDLE) && !AMCI_READ;

  // A channel counts as done once its VALID has dropped or it handshakes now.
  assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_ok  = !M_AXI_WVALID || M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (push) begin
      q_addr[wr_ptr] <= AMCI_WADDR;
      q_data[wr_ptr] <= AMCI_WDATA;
      q_strb[wr_ptr] <= AMCI_WSTRB;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      wstate         <= W_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_count        <= '0;
      M_AXI_AWADDR   <= '0;
      M_AXI_WDATA    <= '0;
      M_AXI_WSTRB    <= '0;
      M_AXI_AWVALID  <= 1'b0;
      M_AXI_WVALID   <= 1'b0;
      M_AXI_BREADY   <= 1'b0;
      AMCI_WRESP     <= '0;
      AMCI_WERRCNT   <= '0;
      AMCI_WOVERFLOW <= 1'b0;
      AMCI_WTIMEOUT  <= 1'b0;
      w_wd           <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (PW+1)'(1);
        2'b01:   q_count <= q_count - (PW+1)'(1);
        default: q_count <= q_count;
      endcase
      if (AMCI_WRITE && AMCI_WFULL) AMCI_WOVERFLOW <= 1'b1;

      case (wstate)
        W_IDLE: begin
          if (pop) begin
            M_AXI_AWADDR  <= q_addr[rd_ptr];
            M_AXI_WDATA   <= q_data[rd_ptr];
            M_AXI_WSTRB   <= q_strb[rd_ptr];
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_BREADY  <= 1'b1;
            w_wd          <= '0;
            wstate        <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_ok && w_ok) wstate <= W_RESP;
        end
        W_RESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            AMCI_WRESP   <= M_AXI_BRESP;
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != 2'b00 && AMCI_WERRCNT != 16'hFFFF)
              AMCI_WERRCNT <= AMCI_WERRCNT + 16'd1;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase

      if (wstate != W_IDLE && WDOG_EN && w_wd != TLIM) begin
        w_wd <= w_wd + TW'(1);
        if (w_wd + TW'(1) == TLIM) AMCI_WTIMEOUT <= 1'b1;
      end

      if (AMCI_CLEAR) begin
        AMCI_WOVERFLOW <= 1'b0;
        AMCI_WTIMEOUT  <= 1'b0;
        AMCI_WERRCNT   <= '0;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      rstate        <= R_IDLE;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      AMCI_RDATA    <= '0;
      AMCI_RRESP    <= '0;
      AMCI_RVALID   <= 1'b0;
      AMCI_RTIMEOUT <= 1'b0;
      r_wd          <= '0;
    end else begin
      AMCI_RVALID <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (AMCI_READ) begin
            M_AXI_ARADDR  <= AMCI_RADDR;
            M_AXI_ARVALID <= 1'b1;
            M_AXI_RREADY  <= 1'b1;
            r_wd          <= '0;
            rstate        <= R_BUSY;
          end
        end
        R_BUSY: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            AMCI_RDATA   <= M_AXI_RDATA;
            AMCI_RRESP   <= M_AXI_RRESP;
            AMCI_RVALID  <= 1'b1;
            M_AXI_RREADY <= 1'b0;
            rstate       <= R_IDLE;
          end
          if (WDOG_EN && r_wd != TLIM) begin
            r_wd <= r_wd + TW'(1);
            if (r_wd + TW'(1) == TLIM) AMCI_RTIMEOUT <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase

      if (AMCI_CLEAR) AMCI_RTIMEOUT <= 1'b0;
    end
  end

endmodule

// File: doc/axi4_lite_master_q.md
Name: axi4_lite_master_q

Overview:
Parametrised AXI4-Lite bus master driven by a discrete-port AMCI-style user interface. Writes are posted into a WFIFO_DEPTH-entry command queue and issued one at a time; reads are single-outstanding. Per-transaction byte strobes, response capture, a saturating write-error counter and per-channel watchdog timeout flags are provided. The block sits between control logic (register sequencers, loaders) and an AXI4-Lite interconnect.

Parameters:
AXI_DATA_WIDTH, 32, data width; must be a multiple of 8.
AXI_ADDR_WIDTH, 32, address width.
WFIFO_DEPTH, 4, write-queue entries; must be a power of 2 and at least 2.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog.

Ports:
M_AXI_ACLK  in  1  the single clock.
M_AXI_ARESET  in  1  synchronous, active-high reset.
AMCI_WADDR  in  AXI_ADDR_WIDTH  write address.
AMCI_WDATA  in  AXI_DATA_WIDTH  write data.
AMCI_WSTRB  in  AXI_DATA_WIDTH/8  write byte strobes.
AMCI_WRITE  in  1  one-cycle enqueue pulse.
AMCI_WFULL  out  1  queue full.
AMCI_WPENDING  out  clog2(WFIFO_DEPTH)+1  entries queued plus in-flight.
AMCI_WIDLE  out  1  queue empty, write FSM idle and AMCI_WRITE low.
AMCI_WRESP  out  2  BRESP of the last completed write.
AMCI_WERRCNT  out  16  saturating count of non-OKAY BRESPs.
AMCI_WOVERFLOW  out  1  sticky: write rejected because the queue was full.
AMCI_WTIMEOUT  out  1  sticky write watchdog flag.
AMCI_RADDR  in  AXI_ADDR_WIDTH  read address.
AMCI_READ  in  1  one-cycle read start pulse.
AMCI_RIDLE  out  1  read FSM idle and AMCI_READ low.
AMCI_RDATA  out  AXI_DATA_WIDTH  captured RDATA.
AMCI_RRESP  out  2  captured RRESP.
AMCI_RVALID  out  1  one-cycle pulse when RDATA/RRESP are updated.
AMCI_RTIMEOUT  out  1  sticky read watchdog flag.
AMCI_CLEAR  in  1  clears WOVERFLOW, WTIMEOUT, RTIMEOUT and WERRCNT.
M_AXI_AW*/W*/B*/AR*/R*  standard AXI4-Lite master ports: AWADDR, AWVALID, AWREADY, AWPROT, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARVALID, ARPROT, ARREADY, RDATA, RRESP, RVALID, RREADY.

Behaviour:
- Reset (synchronous, active-high): all VALID/READY outputs 0, queue emptied, both FSMs idle. WRESP, RRESP, RDATA, WERRCNT and all sticky flags are 0. WIDLE=1, RIDLE=1, WFULL=0, WPENDING=0.
- Reset mid-transaction abandons the AXI transfer. The interconnect must be reset together with this block.
- AWPROT=000, ARPROT=001, both constant.
- Enqueue: an AMCI_WRITE while WFULL=0 stores {addr, data, strb}. An AMCI_WRITE while WFULL=1 is dropped and sets WOVERFLOW, even if a pop happens in the same cycle.
- Write FSM states are IDLE, ADDR_DATA and RESP.
- IDLE with a non-empty queue: pop the head; AWVALID, WVALID and BREADY go to 1 on the next edge. Go to ADDR_DATA.
- Latency: a write enqueued at cycle N into an empty, idle block shows AWVALID=1 at cycle N+2.
- ADDR_DATA: AWVALID and WVALID each drop on the edge after their own handshake. The two handshakes may complete in either order or in the same cycle. Each handshake occurs exactly once. Go to RESP once both are done.
- RESP: on BVALID&BREADY, capture WRESP and increment WERRCNT (saturating at 0xFFFF) if BRESP≠00. Drop BREADY and go to IDLE. The next queued entry launches on the following cycle.
- Writes are issued in enqueue order.
- Read FSM states are IDLE and BUSY.
- IDLE with AMCI_READ: latch ARADDR; ARVALID=1 and RREADY=1 at cycle N+1. AMCI_READ is ignored while BUSY.
- BUSY: ARVALID drops after its handshake. On RVALID&RREADY, capture RDATA/RRESP, pulse AMCI_RVALID in the next cycle, drop RREADY and go to IDLE.
- A read may complete ahead of queued writes. Users needing ordering wait for WIDLE first.
- Watchdog: each FSM has its own cycle counter, which counts while the FSM is not IDLE and reloads to 0 at each launch. When it reaches TIMEOUT_CYCLES, the matching sticky flag sets.
- The FSM keeps waiting after a timeout (AXI-legal); VALID is never withdrawn.
- AMCI_CLEAR wins over a same-cycle flag set or counter increment.

Test Plan:
- Write 0xDEADBEEF to 0x1000 with strb 0xF; AWREADY and WREADY high together; BRESP=00 → one AW and one W handshake, AWVALID at N+2, WRESP=0, WIDLE returns to 1.
- AWREADY 3 cycles ahead of WREADY → AWVALID drops after its handshake, WVALID stays high until WREADY, exactly one beat per channel.
- DEPTH=4, AWREADY held low, 6 back-to-back writes → the 6th is rejected, WOVERFLOW=1, WPENDING=5; after release, 5 writes are issued in order.
- Three writes with BRESP 00, 10, 00 → WERRCNT=1, final WRESP=0; AMCI_CLEAR → WERRCNT=0.
- TIMEOUT_CYCLES=16, read 0x2000 with ARREADY low for 40 cycles → RTIMEOUT=1 at cycle 16 while ARVALID stays 1; then RDATA=0x12345678 is captured, RVALID pulses once.
- Reset asserted during ADDR_DATA with 2 entries queued → next cycle all VALIDs 0, WPENDING=0, WIDLE=1, all flags 0.
